// File: rtl/icache_refill_ctrl_if.sv
// Fetch, L1 and memory-read signals of the instruction refill controller.
// master: the controller; slave: the fetch unit, L1 and memory around it.
interface icache_refill_ctrl_if #(
  parameter int WORD_SIZE = 32,
  parameter int ADDR_SIZE = 14
);
  logic                 cpu_req;
  logic [ADDR_SIZE-1:0] cpu_addr;
  logic                 cpu_ready;
  logic [WORD_SIZE-1:0] cpu_instr;
  logic                 cache_we;
  logic [ADDR_SIZE-1:0] cache_addr;
  logic [WORD_SIZE-1:0] cache_data;
  logic [WORD_SIZE-1:0] cache_dout;
  logic                 cache_hit;
  logic                 mem_req;
  logic [ADDR_SIZE-1:0] mem_addr;
  logic                 mem_ack;
  logic [WORD_SIZE-1:0] mem_data;

  modport master (
    input  cpu_req, cpu_addr,
    input  cache_dout, cache_hit,
    input  mem_ack, mem_data,
    output cpu_ready, cpu_instr,
    output cache_we, cache_addr, cache_data,
    output mem_req, mem_addr
  );

  modport slave (
    output cpu_req, cpu_addr,
    output cache_dout, cache_hit,
    output mem_ack, mem_data,
    input  cpu_ready, cpu_instr,
    input  cache_we, cache_addr, cache_data,
    input  mem_req, mem_addr
  );
endinterface

// File: rtl/icache_refill_ctrl.sv
// Instruction L1 miss/refill controller: serves hits, fills a missing
// line word by word from memory, then replays the original fetch.
module icache_refill_ctrl #(
  parameter int WORD_SIZE      = 32,
  parameter int ADDR_SIZE      = 14,
  parameter int WORDS_PER_LINE = 8,
  parameter int MISS_CNT_BITS  = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  icache_refill_ctrl_if.master     bus,
  output logic                     busy,
  output logic [MISS_CNT_BITS-1:0] miss_count
);
  localparam int OFF_BITS = $clog2(WORDS_PER_LINE);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    REPLAY = 2'd2
  } state_e;

  state_e                   state_q;
  logic [ADDR_SIZE-1:0]     fill_base_q;
  logic [OFF_BITS-1:0]      word_cnt_q;
  logic [MISS_CNT_BITS-1:0] miss_cnt_q;
  logic                     mem_req_q;
  logic                     busy_q;
  logic                     miss;
  logic                     last_word;
  logic [ADDR_SIZE-1:0]     fill_addr;

  assign miss      = (state_q == IDLE) & bus.cpu_req & ~bus.cache_hit;
  assign last_word = (word_cnt_q == OFF_BITS'(WORDS_PER_LINE - 1));
  assign fill_addr = fill_base_q | ADDR_SIZE'(word_cnt_q);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      fill_base_q <= '0;
      word_cnt_q  <= '0;
      miss_cnt_q  <= '0;
      mem_req_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (miss) begin
            state_q     <= FILL;
            fill_base_q <= {bus.cpu_addr[ADDR_SIZE-1:OFF_BITS],
                            {OFF_BITS{1'b0}}};
            word_cnt_q  <= '0;
            mem_req_q   <= 1'b1;
            busy_q      <= 1'b1;
            if (miss_cnt_q != {MISS_CNT_BITS{1'b1}})
              miss_cnt_q <= miss_cnt_q + MISS_CNT_BITS'(1);
          end
        end
        FILL: begin
          if (bus.mem_ack) begin
            word_cnt_q <= word_cnt_q + OFF_BITS'(1);
            if (last_word) begin
              state_q   <= REPLAY;
              mem_req_q <= 1'b0;
            end
          end
        end
        REPLAY: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q   <= IDLE;
          mem_req_q <= 1'b0;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

  // cache_we follows mem_ack directly so the L1 writes on this negedge
  always_comb begin
    bus.cpu_ready  = 1'b0;
    bus.cache_we   = 1'b0;
    bus.cache_addr = bus.cpu_addr;
    bus.mem_addr   = '0;
    unique case (state_q)
      FILL: begin
        bus.cache_we   = bus.mem_ack;
        bus.cache_addr = fill_addr;
        bus.mem_addr   = fill_addr;
      end
      default: begin
        bus.cpu_ready = reset & bus.cpu_req & bus.cache_hit;
      end
    endcase
  end

  assign bus.cache_data = bus.mem_data;
  assign bus.cpu_instr  = bus.cache_dout;
  assign bus.mem_req    = mem_req_q;
  assign busy           = busy_q;
  assign miss_count     = miss_cnt_q;

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Directed bench for icache_refill_ctrl with a behavioural L1 and
// memory; 2-bit miss counter so saturation is reachable.
module tb_icache_refill_ctrl;
  logic       clk;
  logic       reset;
  logic       busy;
  logic [1:0] miss_count;
  int         nvec;
  int         nerr;

  icache_refill_ctrl_if #(.WORD_SIZE(32), .ADDR_SIZE(14)) bus ();

  icache_refill_ctrl #(
    .WORD_SIZE(32),
    .ADDR_SIZE(14),
    .WORDS_PER_LINE(8),
    .MISS_CNT_BITS(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus.master),
    .busy(busy),
    .miss_count(miss_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // L1 model: writes on negedge, line valid only once word 7 lands
  logic [31:0] l1_data [16384];
  bit          l1_valid [2048];

  always @(negedge clk) begin
    if (bus.cache_we) begin
      l1_data[bus.cache_addr] <= bus.cache_data;
      if (bus.cache_addr[2:0] == 3'd7)
        l1_valid[bus.cache_addr[13:3]] <= 1'b1;
    end
  end

  assign bus.cache_hit  = l1_valid[bus.cache_addr[13:3]];
  assign bus.cache_dout = l1_data[bus.cache_addr];

  function automatic logic [31:0] memw(input logic [13:0] a);
    return {16'hC0DE, 2'b00, a};
  endfunction

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp,
               $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic miss_seq(input logic [13:0] a, input bit stall,
                          input bit spur, input logic [1:0] cnt);
    logic [13:0] base;
    logic [13:0] wa;
    int          gap [8];
    gap  = '{0, 3, 1, 2, 0, 3, 2, 1};
    base = {a[13:3], 3'b000};
    bus.cpu_req  = 1'b1;
    bus.cpu_addr = a;
    bus.mem_ack  = 1'b0;
    #1;
    chk("miss_rdy", bus.cpu_ready, 0);
    chk("idle_maddr", bus.mem_addr, 0);
    for (int k = 0; k < 8; k++) begin
      wa = base + 14'(k);
      for (int g = 0; g < (stall ? gap[k] : 0); g++) begin
        tick();
        bus.mem_ack = 1'b0;
        #1;
        chk("stall_req", bus.mem_req, 1);
        chk("stall_addr", bus.mem_addr, wa);
        chk("stall_we", bus.cache_we, 0);
      end
      tick();
      bus.mem_ack  = 1'b1;
      bus.mem_data = memw(wa);
      #1;
      chk("fill_addr", bus.mem_addr, wa);
      chk("fill_caddr", bus.cache_addr, wa);
      chk("fill_we", bus.cache_we, 1);
      chk("fill_rdy", bus.cpu_ready, 0);
      chk("fill_busy", busy, 1);
    end
    tick();
    bus.mem_ack  = spur;
    bus.mem_data = 32'hDEADBEEF;
    #1;
    chk("replay_rdy", bus.cpu_ready, 1);
    chk("replay_ins", bus.cpu_instr, memw(a));
    chk("replay_we", bus.cache_we, 0);
    chk("replay_req", bus.mem_req, 0);
    chk("replay_busy", busy, 1);
    chk("miss_cnt", miss_count, cnt);
    tick();
    bus.cpu_req = 1'b0;
    bus.mem_ack = 1'b0;
    #1;
    chk("post_busy", busy, 0);
    chk("post_cnt", miss_count, cnt);
  endtask

  initial begin
    nvec         = 0;
    nerr         = 0;
    reset        = 1'b0;
    bus.cpu_req  = 1'b0;
    bus.cpu_addr = '0;
    bus.mem_ack  = 1'b0;
    bus.mem_data = '0;
    #3;
    chk("rst_req", bus.mem_req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_we", bus.cache_we, 0);
    chk("rst_rdy", bus.cpu_ready, 0);
    chk("rst_cnt", miss_count, 0);
    tick();
    reset = 1'b1;
    tick();

    // abandon a fill after four acks
    bus.cpu_req  = 1'b1;
    bus.cpu_addr = 14'h1235;
    #1;
    chk("mf_idle", busy, 0);
    for (int k = 0; k < 4; k++) begin
      tick();
      bus.mem_ack  = 1'b1;
      bus.mem_data = memw(14'h1230 + 14'(k));
      #1;
      chk("mf_addr", bus.mem_addr, 14'h1230 + 14'(k));
    end
    tick();
    bus.mem_ack = 1'b0;
    reset       = 1'b0;
    #1;
    chk("mf_req", bus.mem_req, 0);
    chk("mf_busy", busy, 0);
    chk("mf_we", bus.cache_we, 0);
    chk("mf_cnt", miss_count, 0);
    tick();
    bus.cpu_req = 1'b0;
    reset       = 1'b1;
    tick();

    // full refill of the abandoned line, back-to-back acks
    miss_seq(14'h1235, 1'b0, 1'b0, 2'd1);
    tick();
    // stalled memory, spurious ack in REPLAY
    miss_seq(14'h0A12, 1'b1, 1'b1, 2'd2);
    tick();
    miss_seq(14'h0040, 1'b0, 1'b0, 2'd3);
    tick();

    bus.cpu_req  = 1'b1;
    bus.cpu_addr = 14'h0043;
    #1;
    chk("hit_rdy", bus.cpu_ready, 1);
    chk("hit_ins", bus.cpu_instr, memw(14'h0043));
    chk("hit_cnt", miss_count, 3);
    tick();
    bus.cpu_req  = 1'b0;
    bus.mem_ack  = 1'b1;
    bus.mem_data = 32'hDEADBEEF;
    #1;
    chk("spur_we", bus.cache_we, 0);
    chk("hit_busy", busy, 0);
    tick();
    bus.mem_ack = 1'b0;
    #1;
    chk("spur_busy", busy, 0);
    chk("spur_req", bus.mem_req, 0);
    chk("spur_cnt", miss_count, 3);
    tick();

    miss_seq(14'h0300, 1'b0, 1'b0, 2'd3);
    tick();
    miss_seq(14'h030F, 1'b1, 1'b0, 2'd3);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
